// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared constants for the miniRV multi-cycle sequencer: state encodings,
// opcode values and the opcode-class record used by the FSM and Controller.
package mc_ctrl_fsm_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_illegal;
    } opclass_t;

    function automatic opclass_t classify(input logic [6:0] op);
        opclass_t c;
        c = '0;
        case (op)
            OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR: c.is_alu    = 1'b1;
            OP_LOAD:                             c.is_load   = 1'b1;
            OP_STORE:                            c.is_store  = 1'b1;
            OP_BRANCH:                           c.is_branch = 1'b1;
            default:                             c.is_illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opclass_dec.sv
// Combinational opcode classifier: exactly one class flag is high for any opcode.
// Zero latency; shared between the sequencer and the Controller.
module mc_opclass_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_alu,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_illegal
);

    opclass_t cls;

    always_comb begin
        cls        = classify(opcode);
        is_alu     = cls.is_alu;
        is_load    = cls.is_load;
        is_store   = cls.is_store;
        is_branch  = cls.is_branch;
        is_illegal = cls.is_illegal;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes,
// request watchdog, sticky error flags and a retired-instruction counter.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [6:0]  opcode,
    input  logic        br_flag,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_wen,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        retire,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam bit             WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      instret_q, instret_d;

    logic is_alu, is_load, is_store, is_branch, is_illegal;
    logic imem_req_c, dmem_req_c, dmem_wen_c;
    logic ir_we_c, pc_we_c, rf_we_c, retire_c;
    logic wait_c;

    // Branch resolution belongs to the NPC; sequencing never looks at it.
    logic unused_br_flag;
    assign unused_br_flag = br_flag;

    mc_opclass_dec u_opclass_dec (
        .opcode     (opcode),
        .is_alu     (is_alu),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_illegal (is_illegal)
    );

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        instret_d  = instret_q;
        cnt_d      = cnt_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_wen_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        wait_c     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    wait_c = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_illegal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else if (is_alu) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_wen_c = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    wait_c = 1'b1;
                end
            end
            ST_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        // An ack in the final allowed cycle clears wait_c, so it beats the watchdog.
        if (wait_c && WD_EN && (cnt_q == CNT_LAST)) begin
            state_d   = ST_TRAP;
            bus_err_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (retire_c) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    // Reset masks every strobe immediately, including the Mealy ones.
    assign imem_req = imem_req_c & ~cpu_rst;
    assign dmem_req = dmem_req_c & ~cpu_rst;
    assign dmem_wen = dmem_wen_c & ~cpu_rst;
    assign ir_we    = ir_we_c    & ~cpu_rst;
    assign pc_we    = pc_we_c    & ~cpu_rst;
    assign rf_we    = rf_we_c    & ~cpu_rst;
    assign retire   = retire_c   & ~cpu_rst;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomised bench for mc_ctrl_fsm: each instruction is expanded into its
// expected per-cycle trace from the class/latency rules and replayed against the DUT.
module tb_mc_ctrl_fsm;

    localparam int TO = 16;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        br_flag = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire;
    logic [2:0]  state;
    logic        illegal, bus_err;
    logic [31:0] instret;

    always #5 cpu_clk = ~cpu_clk;

    mc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .opcode   (opcode),
        .br_flag  (br_flag),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .dmem_wen (dmem_wen),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .rf_we    (rf_we),
        .retire   (retire),
        .state    (state),
        .illegal  (illegal),
        .bus_err  (bus_err),
        .instret  (instret)
    );

    typedef struct {
        logic [2:0] st;
        logic [6:0] op;
        bit ireq, dreq, wen, irwe, pcwe, rfwe, ret;
        bit iack, dack, rnd_i, rnd_d;
        bit ill, berr;
    } cyc_t;

    cyc_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_no = 0;
    int          br_sel = -1;
    bit          m_ill = 1'b0;
    bit          m_berr = 1'b0;
    logic [31:0] m_instret = 32'd0;
    logic [6:0]  cur_op = 7'd0;

    localparam logic [6:0] LEGAL [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111,
                                         7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

    // 0 = ALU class, 1 = load, 2 = store, 3 = branch, 4 = illegal
    function automatic int cls(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111: return 0;
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            default:    return 4;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input bit ireq, input bit dreq,
                                 input bit wen, input bit irwe, input bit pcwe,
                                 input bit rfwe, input bit ret, input bit iack,
                                 input bit dack, input bit rnd_i, input bit rnd_d);
        cyc_t c;
        c.st = st; c.op = cur_op;
        c.ireq = ireq; c.dreq = dreq; c.wen = wen; c.irwe = irwe;
        c.pcwe = pcwe; c.rfwe = rfwe; c.ret = ret;
        c.iack = iack; c.dack = dack; c.rnd_i = rnd_i; c.rnd_d = rnd_d;
        c.ill = m_ill; c.berr = m_berr;
        exp_q.push_back(c);
    endfunction

    function automatic void push_trap(input int n);
        for (int i = 0; i < n; i++) push(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endfunction

    // Expected trace of one instruction; fwait/mwait >= TO means the ack never comes.
    function automatic void build(input logic [6:0] op, input int fwait, input int mwait);
        int k;
        bit st_;
        k = cls(op);
        st_ = (k == 2);
        cur_op = op;
        if (fwait >= TO) begin
            for (int i = 0; i < TO; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            m_berr = 1'b1;
            push_trap(20);
            return;
        end
        for (int i = 0; i < fwait; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(3'd0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        push(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (k == 4) begin
            m_ill = 1'b1;
            push_trap(20);
            return;
        end
        push(3'd2, 0, 0, 0, 0, k == 3, 0, k == 3, 0, 0, 1, 1);
        if (k == 3) return;
        if (k == 1 || k == 2) begin
            if (mwait >= TO) begin
                for (int i = 0; i < TO; i++) push(3'd3, 0, 1, st_, 0, 0, 0, 0, 0, 0, 1, 0);
                m_berr = 1'b1;
                push_trap(20);
                return;
            end
            for (int i = 0; i < mwait; i++) push(3'd3, 0, 1, st_, 0, 0, 0, 0, 0, 0, 1, 0);
            push(3'd3, 0, 1, st_, 0, st_, 0, st_, 0, 1, 1, 0);
        end
        if (k != 2) push(3'd4, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1);
    endfunction

    // Replays up to n expected cycles (n < 0: all), then drops the rest of the trace.
    task automatic play(input int n);
        cyc_t c;
        logic [11:0] got, expv;
        int lim;
        lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            c = exp_q[i];
            imem_ack = c.rnd_i ? 1'($urandom) : c.iack;
            dmem_ack = c.rnd_d ? 1'($urandom) : c.dack;
            br_flag  = (br_sel < 0) ? 1'($urandom) : br_sel[0];
            opcode   = (c.st == 3'd0 || c.st == 3'd7) ? 7'($urandom) : c.op;
            @(negedge cpu_clk);
            got  = {state, imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire, illegal, bus_err};
            expv = {c.st, c.ireq, c.dreq, c.wen, c.irwe, c.pcwe, c.rfwe, c.ret, c.ill, c.berr};
            n_chk++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL cycle %0d op=%b: {state,ireq,dreq,wen,irwe,pcwe,rfwe,ret,ill,berr} got %b required %b",
                         cyc_no, c.op, got, expv);
            end
            n_chk++;
            if (instret !== m_instret) begin
                n_fail++;
                $display("FAIL instret cycle %0d: got %0d required %0d", cyc_no, instret, m_instret);
            end
            if (c.ret) m_instret = m_instret + 32'd1;
            cyc_no++;
            @(posedge cpu_clk);
            #1;
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        cpu_rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            opcode   = 7'($urandom);
            @(negedge cpu_clk);
            n_chk++;
            if ({imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_strobes: got %b required 0000000",
                         {imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire});
            end
            if (i > 0) begin
                n_chk++;
                if ({state, illegal, bus_err, instret} !== 37'd0) begin
                    n_fail++;
                    $display("FAIL reset_state: state=%0d ill=%b berr=%b instret=%0d required all 0",
                             state, illegal, bus_err, instret);
                end
            end
            @(posedge cpu_clk);
            #1;
        end
        cpu_rst = 1'b0;
        m_ill = 1'b0;
        m_berr = 1'b0;
        m_instret = 32'd0;
    endtask

    task automatic test_reset();
        do_reset(4);
    endtask

    task automatic test_alu();
        build(7'b0110011, 1, 0);
        play(-1);
    endtask

    task automatic test_load();
        build(7'b0000011, 0, 3);
        play(-1);
    endtask

    task automatic test_store();
        build(7'b0100011, 0, 0);
        play(-1);
    endtask

    task automatic test_branch();
        br_sel = 1;
        build(7'b1100011, 0, 0);
        play(-1);
        br_sel = 0;
        build(7'b1100011, 2, 0);
        play(-1);
        br_sel = -1;
    endtask

    task automatic test_illegal();
        build(7'b0000000, 0, 0);
        play(-1);
        do_reset(2);
    endtask

    task automatic test_timeout();
        build(7'b0110011, TO, 0);
        play(-1);
        do_reset(2);
        build(7'b0110011, TO - 1, 0);
        play(-1);
        build(7'b0100011, 0, TO - 1);
        play(-1);
        build(7'b0000011, 1, TO);
        play(-1);
        do_reset(2);
    endtask

    task automatic test_reset_mid();
        build(7'b0010011, 0, 0);
        play(-1);
        build(7'b0000011, 0, 6);
        play(5);
        cpu_rst  = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        @(negedge cpu_clk);
        n_chk++;
        if ({imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid_strobes: got %b required 0000000",
                     {imem_req, dmem_req, dmem_wen, ir_we, pc_we, rf_we, retire});
        end
        @(posedge cpu_clk);
        #1;
        cpu_rst  = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge cpu_clk);
        n_chk++;
        if ({state, instret, imem_req, rf_we} !== {3'd0, 32'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_after: state=%0d instret=%0d ireq=%b rfwe=%b required 0 0 1 0",
                     state, instret, imem_req, rf_we);
        end
        @(posedge cpu_clk);
        #1;
        do_reset(2);
    endtask

    task automatic test_random();
        logic [6:0] op;
        int fw, mw;
        for (int n = 0; n < 300; n++) begin
            op = LEGAL[$urandom_range(0, 7)];
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
            build(op, fw, mw);
            play(-1);
        end
        do begin
            op = 7'($urandom);
        end while (cls(op) != 4);
        build(op, $urandom_range(0, 3), 0);
        play(-1);
        do_reset(2);
    endtask

    initial begin
        @(posedge cpu_clk);
        #1;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle sequencer for the miniRV datapath. It replaces the single-cycle "everything in one clock" scheme with FETCH/DECODE/EXEC/MEM/WB states, so instruction and data memory may be slow, variable-latency bus slaves.
It gates the PC, IR, RF and DRAM write enables and issues req/ack handshakes to IROM and the bus bridge.
The combinational Controller remains responsible for sext_op, alu_op, npc_op and the mux selects. This block decides only *when* state is written.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for ack; 0 disables the watchdog.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  synchronous, active-high reset
opcode  in  7  inst[6:0] taken from the IR (stable between ir_we pulses)
br_flag  in  1  ALU_F branch-taken flag (informational; NPC applies it)
imem_ack  in  1  IROM data valid for the current fetch
dmem_ack  in  1  bridge completed the current load or store
imem_req  out  1  fetch request
dmem_req  out  1  data request
dmem_wen  out  1  store qualifier, valid only while dmem_req=1
ir_we  out  1  latch the fetched instruction into the IR
pc_we  out  1  load npc into the PC
rf_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
state  out  3  current state encoding (debug)
illegal  out  1  sticky flag: unsupported opcode
bus_err  out  1  sticky flag: request watchdog expired
instret  out  32  retired-instruction counter

Behaviour:
- Reset (cpu_clk edge with cpu_rst=1): state=FETCH, wait counter=0, illegal=0, bus_err=0, instret=0. All enables and reqs are 0 while cpu_rst=1. Reset mid-operation aborts the access; no write strobe fires in that cycle.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Opcode classes:
  - R=0110011, I=0010011, LUI=0110111, JAL=1101111, JALR=1100111 → ALU class.
  - LOAD=0000011, STORE=0100011, BRANCH=1100011.
  - Anything else is illegal.
- Output timing: imem_req, dmem_req and dmem_wen are Moore outputs. ir_we, pc_we, rf_we and retire are Mealy, combinational from state plus ack.
- FETCH: imem_req=1. On imem_ack: ir_we=1 in that cycle, next state DECODE. No ack: stay.
- DECODE: one cycle. Illegal opcode → TRAP and set illegal. Otherwise → EXEC.
- EXEC: one cycle.
  - BRANCH: pc_we=1, retire=1, → FETCH.
  - LOAD/STORE → MEM.
  - ALU class → WB.
- MEM: dmem_req=1; dmem_wen=1 only for STORE. On dmem_ack:
  - STORE: pc_we=1, retire=1, → FETCH.
  - LOAD: → WB. rdo must be held by the bridge through WB.
- WB: rf_we=1, pc_we=1, retire=1, → FETCH.
- Instruction latency: ALU class = 4 + fetch wait cycles. Load = 5 + waits. Store = 4 + waits. Branch = 3 + waits.
- Watchdog: the counter clears on every state transition and increments each cycle in FETCH or MEM without ack. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack, the next state is TRAP and bus_err is set. An ack arriving in that same cycle wins: normal transition, no error.
- TRAP: all strobes and reqs 0. Held until cpu_rst. illegal and bus_err hold their values.
- instret: +1 on each cycle with retire=1. Wraps from 0xFFFFFFFF to 0.
- Simultaneous inputs: an ack in a state that does not request it is ignored. br_flag never affects sequencing.

Decomposition:
- Shared package/defines header holds:
  - state encodings (ST_FETCH...ST_TRAP);
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI), next to the existing Controller constants.
- One natural sub-module: mc_opclass_dec. It is purely combinational: opcode → {is_alu, is_load, is_store, is_branch, is_illegal}, and is reused by the Controller.
- FSM, watchdog and instret stay in mc_ctrl_fsm.

Test Plan:
- add x1,x2,x3 (opcode 0110011), imem_ack returned one cycle after req → states 0,1,2,4,0; ir_we, then rf_we, pc_we and retire in the WB cycle; instret=1.
- lw with dmem_ack delayed 3 cycles → dmem_req=1 for 4 cycles, dmem_wen=0; rf_we exactly once in WB; total 8 cycles FETCH-to-FETCH with a 1-cycle fetch.
- sw with immediate dmem_ack → dmem_wen=1 while in MEM; rf_we never asserted; pc_we and retire in the MEM ack cycle.
- beq (1100011) with br_flag=1 and then br_flag=0 → both retire after EXEC; pc_we=1 once; no rf_we or dmem_req.
- opcode 0000000 → DECODE→TRAP; illegal=1; no further imem_req for 20 cycles.
- TIMEOUT=16 with no imem_ack → bus_err=1 and state=7 after 16 FETCH cycles. Repeat with ack on cycle 16 → normal DECODE, bus_err=0. Assert cpu_rst during MEM → no strobes that cycle; state=0 and instret=0 on the next cycle.
